raymarch_frame_scheduler: RTL and testbench

Frame-level controller that drives one rayMarcher instance across a WIDTH x HEIGHT pixel grid. For each pixel it builds the camera ray and issues it to the marcher. It then waits for the result, with a watchdog, and streams one result beat per pixel to the shading/framebuffer stage over a valid/ready handshake. It sits between the frame-control registers and the marcher.

---
 rtl/raymarch_frame_scheduler_pkg.sv | 35 +++
 rtl/raysched_dir_gen.sv | 33 +++
 rtl/raymarch_frame_scheduler.sv | 271 +++++++++++++++++++++++++++
 tb/tb_raymarch_frame_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raymarch_frame_scheduler_pkg.sv
// Shared types for the ray-march frame scheduler.
//   fp_t             : signed Q8.24 fixed-point scalar
//   vec3_t           : packed {x, y, z} vector of fp_t
//   raysched_state_t : frame scheduler FSM states
//   fp_mul_int       : integer-by-fixed-point product, low 32 bits kept
package raymarch_frame_scheduler_pkg;

  typedef logic signed [31:0] fp_t;

  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } vec3_t;

  localparam fp_t   FP_ZERO   = '0;
  localparam vec3_t VEC3_ZERO = '{x: FP_ZERO, y: FP_ZERO, z: FP_ZERO};

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StEmit,
    StDone
  } raysched_state_t;

  // Integer times Q8.24 gives Q8.24 directly, so no shift is applied.
  // Overflow simply wraps; callers keep operands small enough.
  function automatic fp_t fp_mul_int(input fp_t a, input fp_t b);
    fp_t p;
    p = a * b;
    return p;
  endfunction

endpackage

// File: rtl/raysched_dir_gen.sv
// Camera ray direction generator (purely combinational).
//   x, y       : pixel column / row
//   pixel_step : Q8.24 ray slope per pixel
//   focal      : Q8.24 z component of every ray
//   dir        : unnormalised direction
//                ((x - WIDTH/2) * step, (HEIGHT/2 - y) * step, focal)
module raysched_dir_gen
  import raymarch_frame_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned HEIGHT = 48
) (
  input  logic [$clog2(WIDTH)-1:0]  x,
  input  logic [$clog2(HEIGHT)-1:0] y,
  input  fp_t                       pixel_step,
  input  fp_t                       focal,
  output vec3_t                     dir
);

  fp_t off_x;
  fp_t off_y;

  always_comb begin
    // Pixel indices are unsigned; widen before subtracting the centre so the
    // offset comes out as a proper signed 32-bit value.
    off_x = fp_t'(x) - fp_t'(WIDTH / 2);
    off_y = fp_t'(HEIGHT / 2) - fp_t'(y);
    dir.x = fp_mul_int(off_x, pixel_step);
    dir.y = fp_mul_int(off_y, pixel_step);
    dir.z = focal;
  end

endmodule

// File: rtl/raymarch_frame_scheduler.sv
// Frame-level controller for one rayMarcher instance.
// Walks a WIDTH x HEIGHT grid in raster order: for each pixel it issues a
// camera ray, waits (with a watchdog) for the marcher result, then streams
// one result beat downstream over pix_valid/pix_ready.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   start, cam_origin,
//   pixel_step, focal,
//   obj_sel_in          : frame request and config (latched on accepted start)
//   busy, frame_done,
//   timeout_err         : frame status
//   march_*  (out)      : ray issue to marcher (march_valid_in is a 1-cycle pulse)
//   march_valid_out,
//   march_hit,
//   march_point         : marcher result
//   pix_*               : result beat stream to the shading stage
//
// Optional: define RAYSCHED_PERF_EN to add perf_cycles / perf_hits counters.
module raymarch_frame_scheduler
  import raymarch_frame_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned HEIGHT         = 48,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  vec3_t                     cam_origin,
  input  fp_t                       pixel_step,
  input  fp_t                       focal,
  input  logic                      obj_sel_in,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      timeout_err,
  output logic                      march_valid_in,
  output vec3_t                     march_origin,
  output vec3_t                     march_dir,
  output logic                      march_obj_sel,
  input  logic                      march_valid_out,
  input  logic                      march_hit,
  input  vec3_t                     march_point,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      pix_hit,
  output vec3_t                     pix_point,
  output logic [$clog2(WIDTH)-1:0]  pix_x,
  output logic [$clog2(HEIGHT)-1:0] pix_y,
  output logic                      pix_sof,
  output logic                      pix_eol
`ifdef RAYSCHED_PERF_EN
  ,
  output logic [31:0]               perf_cycles,
  output logic [31:0]               perf_hits
`endif
);

  localparam int unsigned XW    = $clog2(WIDTH);
  localparam int unsigned YW    = $clog2(HEIGHT);
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [XW-1:0]    XLast    = XW'(WIDTH - 1);
  localparam logic [YW-1:0]    YLast    = YW'(HEIGHT - 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

  raysched_state_t   state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [WdogW-1:0]  wdog_q, wdog_d;
  fp_t               step_q, step_d;
  fp_t               focal_q, focal_d;
  vec3_t             origin_q, origin_d;
  logic              obj_sel_q, obj_sel_d;
  vec3_t             dir_q, dir_d;
  logic              hit_q, hit_d;
  vec3_t             point_q, point_d;
  logic              terr_q, terr_d;

  // Raster advance and direction-generator operands
  logic [XW-1:0]     x_adv, gen_x;
  logic [YW-1:0]     y_adv, gen_y;
  fp_t               gen_step, gen_focal;
  vec3_t             dir_next;
  logic              last_pix;

  always_comb begin
    x_adv = x_q + 1'b1;
    y_adv = y_q;
    if (x_q == XLast) begin
      x_adv = '0;
      y_adv = y_q + 1'b1;
    end
    last_pix = (x_q == XLast) && (y_q == YLast);

    // In IDLE the config registers are not loaded yet, so the first ray is
    // built straight from the inputs being latched this cycle.
    if (state_q == StIdle) begin
      gen_x     = '0;
      gen_y     = '0;
      gen_step  = pixel_step;
      gen_focal = focal;
    end else begin
      gen_x     = x_adv;
      gen_y     = y_adv;
      gen_step  = step_q;
      gen_focal = focal_q;
    end
  end

  raysched_dir_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_dir_gen (
    .x          (gen_x),
    .y          (gen_y),
    .pixel_step (gen_step),
    .focal      (gen_focal),
    .dir        (dir_next)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    wdog_d    = wdog_q;
    step_d    = step_q;
    focal_d   = focal_q;
    origin_d  = origin_q;
    obj_sel_d = obj_sel_q;
    dir_d     = dir_q;
    hit_d     = hit_q;
    point_d   = point_q;
    terr_d    = terr_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          step_d    = pixel_step;
          focal_d   = focal;
          origin_d  = cam_origin;
          obj_sel_d = obj_sel_in;
          x_d       = '0;
          y_d       = '0;
          terr_d    = 1'b0;
          dir_d     = dir_next;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        // march_valid_out is deliberately not looked at here: a strobe that
        // arrives in the issue cycle belongs to an older ray.
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (march_valid_out) begin
          hit_d   = march_hit;
          point_d = march_point;
          state_d = StEmit;
        end else if (wdog_q == WdogLast) begin
          hit_d   = 1'b0;
          point_d = VEC3_ZERO;
          terr_d  = 1'b1;
          state_d = StEmit;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StEmit: begin
        if (pix_ready) begin
          if (last_pix) begin
            state_d = StDone;
          end else begin
            x_d     = x_adv;
            y_d     = y_adv;
            dir_d   = dir_next;
            state_d = StIssue;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      wdog_q    <= '0;
      step_q    <= FP_ZERO;
      focal_q   <= FP_ZERO;
      origin_q  <= VEC3_ZERO;
      obj_sel_q <= 1'b0;
      dir_q     <= VEC3_ZERO;
      hit_q     <= 1'b0;
      point_q   <= VEC3_ZERO;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      wdog_q    <= wdog_d;
      step_q    <= step_d;
      focal_q   <= focal_d;
      origin_q  <= origin_d;
      obj_sel_q <= obj_sel_d;
      dir_q     <= dir_d;
      hit_q     <= hit_d;
      point_q   <= point_d;
      terr_q    <= terr_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign frame_done     = (state_q == StDone);
  assign timeout_err    = terr_q;
  assign march_valid_in = (state_q == StIssue);
  assign march_origin   = origin_q;
  assign march_dir      = dir_q;
  assign march_obj_sel  = obj_sel_q;
  assign pix_valid      = (state_q == StEmit);
  assign pix_hit        = hit_q;
  assign pix_point      = point_q;
  assign pix_x          = x_q;
  assign pix_y          = y_q;
  assign pix_sof        = pix_valid && (x_q == '0) && (y_q == '0);
  assign pix_eol        = pix_valid && (x_q == XLast);

`ifdef RAYSCHED_PERF_EN
  logic [31:0] pcyc_q, pcyc_d;
  logic [31:0] phit_q, phit_d;

  always_comb begin
    pcyc_d = pcyc_q;
    phit_d = phit_q;
    if (state_q == StIdle) begin
      // The accepting cycle itself counts as the first frame cycle.
      if (start) begin
        pcyc_d = 32'd1;
        phit_d = '0;
      end
    end else begin
      pcyc_d = pcyc_q + 32'd1;
    end
    if ((state_q == StEmit) && pix_ready && hit_q) begin
      phit_d = phit_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcyc_q <= '0;
      phit_q <= '0;
    end else begin
      pcyc_q <= pcyc_d;
      phit_q <= phit_d;
    end
  end

  assign perf_cycles = pcyc_q;
  assign perf_hits   = phit_q;
`endif

endmodule

// File: tb/tb_raymarch_frame_scheduler.sv
// Directed bench for raymarch_frame_scheduler on a 4x2 grid with a stub
// marcher of 3-cycle latency (hit when pixel x is even).
`timescale 1ns/1ps
module tb_raymarch_frame_scheduler;
  import raymarch_frame_scheduler_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned TO = 16;
  localparam fp_t   STEP  = 32'h0010_0000;
  localparam fp_t   FOCAL = 32'h0100_0000;
  localparam vec3_t CAM   = '{x: 32'h0000_1111, y: 32'h0000_2222, z: 32'h7FFF_0000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  vec3_t       cam_origin = VEC3_ZERO;
  fp_t         pixel_step = FP_ZERO;
  fp_t         focal = FP_ZERO;
  logic        obj_sel_in = 1'b0;
  logic        busy, frame_done, timeout_err, march_valid_in, march_obj_sel;
  vec3_t       march_origin, march_dir, march_point, pix_point;
  logic        march_valid_out, march_hit;
  logic        pix_valid, pix_hit, pix_sof, pix_eol;
  logic        pix_ready = 1'b1;
  logic [1:0]  pix_x;
  logic [0:0]  pix_y;
`ifdef RAYSCHED_PERF_EN
  logic [31:0] perf_cycles, perf_hits;
`endif

  raymarch_frame_scheduler #(
    .WIDTH          (W),
    .HEIGHT         (H),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cam_origin      (cam_origin),
    .pixel_step      (pixel_step),
    .focal           (focal),
    .obj_sel_in      (obj_sel_in),
    .busy            (busy),
    .frame_done      (frame_done),
    .timeout_err     (timeout_err),
    .march_valid_in  (march_valid_in),
    .march_origin    (march_origin),
    .march_dir       (march_dir),
    .march_obj_sel   (march_obj_sel),
    .march_valid_out (march_valid_out),
    .march_hit       (march_hit),
    .march_point     (march_point),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_hit         (pix_hit),
    .pix_point       (pix_point),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .pix_sof         (pix_sof),
    .pix_eol         (pix_eol)
`ifdef RAYSCHED_PERF_EN
    ,
    .perf_cycles     (perf_cycles),
    .perf_hits       (perf_hits)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- stub marcher ----------------
  int  cyc = 0;
  int  stub_cnt = 0;
  int  stub_px = 0;
  int  stub_py = 0;
  bit  drop_en = 1'b0;
  bit  inj = 1'b0;

  function automatic int dec_x(input fp_t d);
    return int'($signed(d) >>> 20) + 2;
  endfunction
  function automatic int dec_y(input fp_t d);
    return 1 - int'($signed(d) >>> 20);
  endfunction
  function automatic vec3_t stub_pt(input int px, input int py);
    vec3_t p;
    p.x = fp_t'(32'h100 + px);
    p.y = fp_t'(32'h200 + py);
    p.z = fp_t'(32'h300 + px + 4 * py);
    return p;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      stub_cnt <= 0;
    end else if (march_valid_in) begin
      stub_px  <= dec_x(march_dir.x);
      stub_py  <= dec_y(march_dir.y);
      stub_cnt <= (drop_en && dec_x(march_dir.x) == 1 && dec_y(march_dir.y) == 0) ? 0 : 3;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  assign march_valid_out = (stub_cnt == 1) || inj;
  assign march_hit       = (stub_px % 2) == 0;
  assign march_point     = stub_pt(stub_px, stub_py);

  // ---------------- monitor ----------------
  typedef struct packed {
    logic [1:0] x;
    logic [0:0] y;
    logic       hit;
    logic       sof;
    logic       eol;
    vec3_t      point;
  } beat_t;

  typedef struct {
    int    cyc;
    vec3_t dir;
  } iss_t;

  beat_t beats_q[$];
  iss_t  issue_q[$];
  int    vstart_q[$];
  int    n_done = 0;
  int    done_cyc = 0;
  int    last_hs_cyc = 0;
  bit    prev_valid = 1'b0;

  always @(negedge clk) begin
    beat_t b;
    iss_t  r;
    if (march_valid_in) begin
      r.cyc = cyc;
      r.dir = march_dir;
      issue_q.push_back(r);
    end
    if (pix_valid && !prev_valid) vstart_q.push_back(cyc);
    prev_valid = pix_valid;
    if (pix_valid && pix_ready) begin
      b.x = pix_x; b.y = pix_y; b.hit = pix_hit;
      b.sof = pix_sof; b.eol = pix_eol; b.point = pix_point;
      beats_q.push_back(b);
      last_hs_cyc = cyc;
    end
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  // ---------------- checking ----------------
  typedef struct {
    int    px;
    int    py;
    bit    hit;
    bit    sof;
    bit    eol;
    vec3_t dir;
  } vec_t;

  vec_t vecs[8];
  int   n_tests = 0;
  int   n_fail = 0;
  int   start_cyc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input int px, input int py, input bit hit, input bit sof,
                         input bit eol, input logic [31:0] dx, input logic [31:0] dy);
    vecs[i].px = px; vecs[i].py = py; vecs[i].hit = hit;
    vecs[i].sof = sof; vecs[i].eol = eol;
    vecs[i].dir.x = dx; vecs[i].dir.y = dy; vecs[i].dir.z = FOCAL;
  endtask

  task automatic start_frame();
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base_done);
    bit ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      if (n_done > base_done) ok = 1'b1;
    end
    if (!ok) check({tag, " frame_done seen"}, 0, 1);
  endtask

  task automatic check_frame(input string tag, input int bbase, input int ibase, input int tout);
    beat_t e;
    int    lat;
    check({tag, " beat count"}, beats_q.size() - bbase, 8);
    check({tag, " issue count"}, issue_q.size() - ibase, 8);
    for (int i = 0; i < 8; i++) begin
      e.x     = 2'(vecs[i].px);
      e.y     = 1'(vecs[i].py);
      e.hit   = (i == tout) ? 1'b0 : vecs[i].hit;
      e.sof   = vecs[i].sof;
      e.eol   = vecs[i].eol;
      e.point = (i == tout) ? VEC3_ZERO : stub_pt(vecs[i].px, vecs[i].py);
      if (bbase + i < beats_q.size())
        check($sformatf("%s beat%0d", tag, i), beats_q[bbase + i], e);
      if (ibase + i < issue_q.size()) begin
        check($sformatf("%s dir%0d", tag, i), issue_q[ibase + i].dir, vecs[i].dir);
        if (bbase + i < vstart_q.size()) begin
          lat = vstart_q[bbase + i] - issue_q[ibase + i].cyc;
          check($sformatf("%s latency%0d", tag, i), lat, (i == tout) ? 17 : 4);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin
    int  bb, ib, nd, iss0;
    bit  stable, seen;
    beat_t snap, cur;

    set_vec(0, 0, 0, 1'b1, 1'b1, 1'b0, 32'hFFE0_0000, 32'h0010_0000);
    set_vec(1, 1, 0, 1'b0, 1'b0, 1'b0, 32'hFFF0_0000, 32'h0010_0000);
    set_vec(2, 2, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0010_0000);
    set_vec(3, 3, 0, 1'b0, 1'b0, 1'b1, 32'h0010_0000, 32'h0010_0000);
    set_vec(4, 0, 1, 1'b1, 1'b0, 1'b0, 32'hFFE0_0000, 32'h0000_0000);
    set_vec(5, 1, 1, 1'b0, 1'b0, 1'b0, 32'hFFF0_0000, 32'h0000_0000);
    set_vec(6, 2, 1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    set_vec(7, 3, 1, 1'b0, 1'b0, 1'b1, 32'h0010_0000, 32'h0000_0000);

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("reset flags",
          {busy, frame_done, timeout_err, march_valid_in, pix_valid, pix_hit, pix_sof, pix_eol,
           march_obj_sel, pix_x, pix_y}, '0);
    check("reset march_dir", march_dir, VEC3_ZERO);
    check("reset march_origin", march_origin, VEC3_ZERO);
    check("reset pix_point", pix_point, VEC3_ZERO);
    tick();
    rst = 1'b0;

    // Frame A: plain frame, config changed after start to prove latching
    cam_origin = CAM; pixel_step = STEP; focal = FOCAL; obj_sel_in = 1'b1;
    bb = beats_q.size(); ib = issue_q.size(); nd = n_done;
    start_frame();
    cam_origin = VEC3_ZERO; obj_sel_in = 1'b0; pixel_step = 32'h0123_4567; focal = FP_ZERO;
    wait_done("A", nd);
    check_frame("A", bb, ib, -1);
    check("A march_origin", march_origin, CAM);
    check("A march_obj_sel", march_obj_sel, 1'b1);
    check("A timeout_err", timeout_err, 1'b0);
    check("A done after last handshake", done_cyc - last_hs_cyc, 1);
    @(negedge clk);
    check("A idle after done", {busy, frame_done}, 2'b00);

    // Frame B: backpressure on beat 2
    cam_origin = CAM; pixel_step = STEP; focal = FOCAL; obj_sel_in = 1'b1;
    tick();
    bb = beats_q.size(); ib = issue_q.size(); nd = n_done;
    start_frame();
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (beats_q.size() - bb == 2) seen = 1'b1;
      else tick();
    end
    pix_ready = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (pix_valid) seen = 1'b1;
    end
    check("B beat2 valid reached", seen, 1'b1);
    snap.x = pix_x; snap.y = pix_y; snap.hit = pix_hit;
    snap.sof = pix_sof; snap.eol = pix_eol; snap.point = pix_point;
    iss0 = issue_q.size();
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      cur.x = pix_x; cur.y = pix_y; cur.hit = pix_hit;
      cur.sof = pix_sof; cur.eol = pix_eol; cur.point = pix_point;
      if (!pix_valid || cur !== snap) stable = 1'b0;
    end
    check("B held beat stable", stable, 1'b1);
    check("B no issue while stalled", issue_q.size() - iss0, 0);
    tick();
    pix_ready = 1'b1;
    wait_done("B", nd);
    check_frame("B", bb, ib, -1);

    // Frame C: marcher never answers pixel (1,0)
    tick();
    drop_en = 1'b1;
    bb = beats_q.size(); ib = issue_q.size(); nd = n_done;
    start_frame();
    wait_done("C", nd);
    check_frame("C", bb, ib, 1);
    check("C timeout_err at done", timeout_err, 1'b1);
    repeat (5) @(negedge clk);
    check("C timeout_err sticky", timeout_err, 1'b1);
    drop_en = 1'b0;

    // Frame D: reset while waiting on the first result
    tick();
    ib = issue_q.size(); nd = n_done;
    start_frame();
    @(negedge clk);
    check("D timeout_err cleared on start", timeout_err, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (issue_q.size() > ib) seen = 1'b1;
      else @(negedge clk);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("D reset flags",
          {busy, frame_done, timeout_err, march_valid_in, pix_valid, pix_hit, pix_sof, pix_eol,
           march_obj_sel, pix_x, pix_y}, '0);
    check("D reset march_dir", march_dir, VEC3_ZERO);
    repeat (30) @(negedge clk);
    check("D no frame_done after reset", n_done - nd, 0);
    check("D still idle", busy, 1'b0);

    // Frame E: fresh frame after reset
    tick();
    bb = beats_q.size(); ib = issue_q.size(); nd = n_done;
    start_frame();
    wait_done("E", nd);
    check_frame("E", bb, ib, -1);

    // Frame F: start while busy and a stray result strobe in ISSUE of pixel 3
    tick();
    bb = beats_q.size(); ib = issue_q.size(); nd = n_done;
    start_frame();
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (march_valid_in && issue_q.size() - ib == 3) seen = 1'b1;
      else tick();
    end
    check("F issue3 reached", seen, 1'b1);
    inj = 1'b1; start = 1'b1; pixel_step = 32'h0040_0000;
    tick();
    inj = 1'b0; start = 1'b0; pixel_step = STEP;
    wait_done("F", nd);
    check_frame("F", bb, ib, -1);
`ifdef RAYSCHED_PERF_EN
    check("F perf_hits", perf_hits, 32'd4);
    check("F perf_cycles", perf_cycles, 32'(done_cyc - start_cyc + 1));
`endif
    repeat (20) @(negedge clk);
    check("F single frame_done", n_done - nd, 1);
    check("F no restart", {busy, 32'(issue_q.size() - ib)}, {1'b0, 32'd8});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
